// File: rtl/dvp_pkg.sv
// Shared definitions for the DVP capture path: FSM encodings, vsync polarity
// encodings and the window membership test.
package dvp_pkg;

   localparam logic [1:0] ST_WAIT_CONF = 2'd0;
   localparam logic [1:0] ST_WAIT_VS   = 2'd1;
   localparam logic [1:0] ST_SKIP      = 2'd2;
   localparam logic [1:0] ST_ACTIVE    = 2'd3;

   // vsync level that marks vertical blanking
   localparam int VSYNC_BLANK_LOW  = 0;
   localparam int VSYNC_BLANK_HIGH = 1;

   // True when pos lies in [lo, lo+len)
   function automatic logic win_hit(input int pos, input int lo, input int len);
      return (pos >= lo) && (pos < lo + len);
   endfunction

endpackage

// File: rtl/dvp_byte_packer.sv
// Collects BYTES_PER_PIX sensor beats into one pixel word, first beat in the
// MSBs. pix_done/pix_word are combinational so the top can register the pixel
// together with its window decision in the same edge.
module dvp_byte_packer
   import dvp_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2
) (
   input  logic                              camera_pclk,
   input  logic                              rst,
   input  logic                              en,
   input  logic                              href_fall,
   input  logic [DATA_W-1:0]                 data,
   output logic                              pix_done,
   output logic [DATA_W*BYTES_PER_PIX-1:0]   pix_word,
   output logic                              partial_err
);

   localparam int         PIX_W = DATA_W * BYTES_PER_PIX;
   localparam logic [1:0] LAST  = 2'(BYTES_PER_PIX - 1);

   logic [1:0]       beat_cnt;
   logic [PIX_W-1:0] shift_q;

   assign pix_done    = en && (beat_cnt == LAST);
   assign pix_word    = (shift_q << DATA_W) | PIX_W'(data);
   // The counter still holds the last line's beat count in the cycle href is seen low
   assign partial_err = href_fall && (beat_cnt != 2'd0);

   // Beat counter and shift register; any gap in href or a blanking start drops a partial pixel
   always_ff @(posedge camera_pclk) begin
      if (rst) begin
         beat_cnt <= 2'd0;
         shift_q  <= '0;
      end else if (!en) begin
         beat_cnt <= 2'd0;
      end else begin
         shift_q  <= pix_word;
         beat_cnt <= pix_done ? 2'd0 : beat_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/dvp_pixel_capture.sv
// DVP camera front end: registers the sensor pins, packs beats into pixels,
// skips settling frames, crops to a window and produces frame bookkeeping.
//
// state         | meaning
// ST_WAIT_CONF  | sensor not configured, nothing captured
// ST_WAIT_VS    | waiting for end of vertical blanking to start a frame
// ST_SKIP       | settling frame in progress, pixels discarded
// ST_ACTIVE     | frame being captured
module dvp_pixel_capture
   import dvp_pkg::*;
#(
   parameter int DATA_W        = 8,
   parameter int BYTES_PER_PIX = 2,
   parameter int H_CNT_W       = 12,
   parameter int V_CNT_W       = 11,
   parameter int WIN_X0        = 0,
   parameter int WIN_W         = 1024,
   parameter int WIN_Y0        = 0,
   parameter int WIN_H         = 768,
   parameter int SKIP_FRAMES   = 2,
   parameter int VSYNC_POL     = 1
) (
   input  logic                              camera_pclk,
   input  logic                              rst,
   input  logic                              reg_conf_done,
   input  logic                              camera_href,
   input  logic                              camera_vsync,
   input  logic [DATA_W-1:0]                 camera_data,
   output logic [DATA_W*BYTES_PER_PIX-1:0]   pix_data,
   output logic                              pix_valid,
   output logic                              pix_sof,
   output logic                              pix_eol,
   output logic [H_CNT_W-1:0]                h_count,
   output logic [V_CNT_W-1:0]                v_count,
   output logic                              frame_done,
   output logic                              line_len_err,
   output logic [15:0]                       frame_cnt,
   output logic                              fifo_rst
);

   logic                href_r, href_q, vsync_r, vs_q;
   logic [DATA_W-1:0]   data_r;
   logic                vs_act, vs_rise, vs_fall, href_fall;
   logic [1:0]          state;
   logic [7:0]          skip_cnt;
   logic [H_CNT_W-1:0]  h_idx;
   logic                pix_done, partial_err, in_win;
   logic [DATA_W*BYTES_PER_PIX-1:0] pix_word;

   assign vs_act    = (VSYNC_POL == VSYNC_BLANK_HIGH) ? vsync_r : ~vsync_r;
   assign vs_rise   = vs_act & ~vs_q;
   assign vs_fall   = ~vs_act & vs_q;
   assign href_fall = href_q & ~href_r;
   assign fifo_rst  = vs_q | rst;
   assign in_win    = (state == ST_ACTIVE)
                    && win_hit(int'(h_idx), WIN_X0, WIN_W)
                    && win_hit(int'(v_count), WIN_Y0, WIN_H);

   // Input stage plus one-cycle history for edge detection
   always_ff @(posedge camera_pclk) begin
      if (rst) begin
         href_r  <= 1'b0;
         href_q  <= 1'b0;
         vsync_r <= 1'b0;
         vs_q    <= 1'b0;
         data_r  <= '0;
      end else begin
         href_r  <= camera_href;
         href_q  <= href_r;
         vsync_r <= camera_vsync;
         vs_q    <= vs_act;
         data_r  <= camera_data;
      end
   end

   dvp_byte_packer #(
      .DATA_W        (DATA_W),
      .BYTES_PER_PIX (BYTES_PER_PIX)
   ) u_packer (
      .camera_pclk (camera_pclk),
      .rst         (rst),
      .en          (href_r & ~vs_act),
      .href_fall   (href_fall),
      .data        (data_r),
      .pix_done    (pix_done),
      .pix_word    (pix_word),
      .partial_err (partial_err)
   );

   // Frame sequencing; dropping reg_conf_done abandons everything including the skip count
   always_ff @(posedge camera_pclk) begin
      if (rst) begin
         state      <= ST_WAIT_CONF;
         skip_cnt   <= 8'd0;
         frame_done <= 1'b0;
         frame_cnt  <= 16'd0;
      end else begin
         frame_done <= 1'b0;
         if (!reg_conf_done) begin
            state    <= ST_WAIT_CONF;
            skip_cnt <= 8'd0;
         end else begin
            case (state)
               ST_WAIT_CONF: state <= ST_WAIT_VS;
               ST_WAIT_VS: begin
                  if (vs_fall)
                     state <= (skip_cnt < 8'(SKIP_FRAMES)) ? ST_SKIP : ST_ACTIVE;
               end
               ST_SKIP: begin
                  if (vs_rise) begin
                     skip_cnt <= skip_cnt + 8'd1;
                     state    <= ST_WAIT_VS;
                  end
               end
               ST_ACTIVE: begin
                  if (vs_rise) begin
                     frame_done <= 1'b1;
                     frame_cnt  <= frame_cnt + 16'd1;
                     state      <= ST_WAIT_VS;
                  end
               end
               default: state <= ST_WAIT_CONF;
            endcase
         end
      end
   end

   // Pixel/line position; h_idx is the next pixel's index, h_count the last emitted one
   always_ff @(posedge camera_pclk) begin
      if (rst) begin
         h_idx   <= '0;
         h_count <= '0;
         v_count <= '0;
      end else begin
         if (!href_r) begin
            h_idx   <= '0;
            h_count <= '0;
         end else if (pix_done) begin
            h_count <= h_idx;
            if (h_idx != '1)
               h_idx <= h_idx + 1'b1;
         end
         if (vs_act)
            v_count <= '0;
         else if (href_fall && (v_count != '1))
            v_count <= v_count + 1'b1;
      end
   end

   // Windowed pixel output, strobes and the sticky partial-pixel flag
   always_ff @(posedge camera_pclk) begin
      if (rst) begin
         pix_data     <= '0;
         pix_valid    <= 1'b0;
         pix_sof      <= 1'b0;
         pix_eol      <= 1'b0;
         line_len_err <= 1'b0;
      end else begin
         pix_valid <= 1'b0;
         pix_sof   <= 1'b0;
         pix_eol   <= 1'b0;
         if (partial_err)
            line_len_err <= 1'b1;
         if (pix_done && in_win) begin
            pix_valid <= 1'b1;
            pix_data  <= pix_word;
            pix_sof   <= (h_idx == H_CNT_W'(WIN_X0)) && (v_count == V_CNT_W'(WIN_Y0));
            pix_eol   <= (h_idx == H_CNT_W'(WIN_X0 + WIN_W - 1));
         end
      end
   end

endmodule
